// File: rtl/mesh_store.sv
// mesh_store: renderer geometry store. Vertex/triangle RAMs with bump
// allocation, mesh descriptor tables, instance table and 2-stage lookup.
// Ports: cmd_*/data_* load stream (valid/ready), rd_* instance lookup,
// vert_rd_*/tri_rd_* flat RAM reads, vert_used/tri_used, sticky err.
module mesh_store #(
  parameter int MAX_VERT = 8192,
  parameter int MAX_TRI  = 8192,
  parameter int MAX_MESH = 256,
  parameter int MAX_INST = 256,
  parameter int VTX_W    = 108,
  parameter int TRI_W    = 24,
  parameter int XFORM_W  = 384,
  localparam int VA_W  = $clog2(MAX_VERT),
  localparam int TA_W  = $clog2(MAX_TRI),
  localparam int MID_W = $clog2(MAX_MESH),
  localparam int IID_W = $clog2(MAX_INST),
  localparam int IN_W  = XFORM_W + 2*MID_W,
  localparam int VC_W  = VA_W + 1,
  localparam int TC_W  = TA_W + 1,
  localparam int ID_W  = (MID_W > IID_W) ? MID_W : IID_W,
  localparam int CNT_W = (VC_W > TC_W) ? VC_W : TC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [CNT_W-1:0]   cmd_count,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [IN_W-1:0]    data_in,
  input  logic               rd_req,
  input  logic [IID_W-1:0]   rd_inst_id,
  output logic               rd_valid,
  output logic               rd_inst_ok,
  output logic [XFORM_W-1:0] rd_xform,
  output logic [VA_W-1:0]    rd_vert_base,
  output logic [VC_W-1:0]    rd_vert_count,
  output logic [TA_W-1:0]    rd_tri_base,
  output logic [TC_W-1:0]    rd_tri_count,
  input  logic [VA_W-1:0]    vert_rd_addr,
  output logic [VTX_W-1:0]   vert_rd_data,
  input  logic [TA_W-1:0]    tri_rd_addr,
  output logic [TRI_W-1:0]   tri_rd_data,
  output logic [VC_W-1:0]    vert_used,
  output logic [TC_W-1:0]    tri_used,
  output logic [1:0]         err
);

  typedef enum logic [2:0] {
    IDLE, VDATA, TDATA, IDATA, URD, UWR
  } state_t;

  localparam logic [2:0] OP_WIPE  = 3'd0;
  localparam logic [2:0] OP_VMESH = 3'd1;
  localparam logic [2:0] OP_TMESH = 3'd2;
  localparam logic [2:0] OP_ICRT  = 3'd3;
  localparam logic [2:0] OP_IUPD  = 3'd4;
  localparam int SUM_W = CNT_W + 1;

  state_t state, state_nxt;
  logic init_q;
  logic [ID_W-1:0]  lat_id;
  logic [CNT_W-1:0] lat_cnt, lat_base, beat;
  logic discard;

  logic [VTX_W-1:0] vram [MAX_VERT];
  logic [TRI_W-1:0] tram [MAX_TRI];
  logic [IN_W-1:0]  iram [MAX_INST];
  logic [VA_W-1:0]  vd_base [MAX_MESH];
  logic [VC_W-1:0]  vd_cnt  [MAX_MESH];
  logic [TA_W-1:0]  td_base [MAX_MESH];
  logic [TC_W-1:0]  td_cnt  [MAX_MESH];
  logic [MAX_MESH-1:0] vmesh_v, tmesh_v;
  logic [MAX_INST-1:0] inst_v;

  logic acc, beat_ok, last;
  logic op_v, op_t, op_i, op_u;
  logic wipe, illegal, ovf_acc;
  logic [SUM_W-1:0] v_sum, t_sum;
  logic v_ovf, t_ovf;
  logic v_beat, t_beat, u_beat;
  logic v_cmt, t_cmt, vd_we, td_we;
  logic v_wr, t_wr, i_wr, u_bad;
  logic [MID_W-1:0] d_id;
  logic [IID_W-1:0] iid_lat;
  logic [CNT_W-1:0] d_base, d_cnt, wa;
  logic [IN_W-1:0]  i_wdata;
  logic [2*MID_W-1:0] ia_q;
  logic [IN_W-1:0]  ib_q;
  logic s1_v, s1_iv;
  logic [MID_W-1:0] s1_vm, s1_tm;

  assign acc     = cmd_valid & cmd_ready;
  assign beat_ok = data_valid & data_ready;
  assign last    = (beat + CNT_W'(1)) == lat_cnt;
  assign op_v    = acc & (cmd_op == OP_VMESH);
  assign op_t    = acc & (cmd_op == OP_TMESH);
  assign op_i    = acc & (cmd_op == OP_ICRT);
  assign op_u    = acc & (cmd_op == OP_IUPD);
  assign wipe    = acc & (cmd_op == OP_WIPE);
  assign illegal = acc & (cmd_op > OP_IUPD);

  // Overflow is judged on the whole request before any beat is taken.
  assign v_sum   = SUM_W'(vert_used) + SUM_W'(cmd_count);
  assign t_sum   = SUM_W'(tri_used) + SUM_W'(cmd_count);
  assign v_ovf   = v_sum > SUM_W'(MAX_VERT);
  assign t_ovf   = t_sum > SUM_W'(MAX_TRI);
  assign ovf_acc = (op_v & v_ovf) | (op_t & t_ovf);

  assign v_beat  = (state == VDATA) & beat_ok;
  assign t_beat  = (state == TDATA) & beat_ok;
  assign u_beat  = (state == UWR) & beat_ok;
  assign v_wr    = v_beat & ~discard;
  assign t_wr    = t_beat & ~discard;
  assign v_cmt   = v_wr & last;
  assign t_cmt   = t_wr & last;

  // Empty meshes commit in the accept cycle; others on the last beat.
  assign vd_we   = (op_v & (cmd_count == '0)) | v_cmt;
  assign td_we   = (op_t & (cmd_count == '0)) | t_cmt;
  assign d_id    = acc ? cmd_id[MID_W-1:0] : lat_id[MID_W-1:0];
  assign d_base  = acc ? (op_t ? CNT_W'(tri_used) : CNT_W'(vert_used))
                       : lat_base;
  assign d_cnt   = acc ? '0 : lat_cnt;
  assign wa      = lat_base + beat;

  assign iid_lat = lat_id[IID_W-1:0];
  assign u_bad   = u_beat & ~inst_v[iid_lat];
  assign i_wr    = ((state == IDATA) & beat_ok) | (u_beat & inst_v[iid_lat]);
  assign i_wdata = (state == IDATA) ? data_in
                 : {data_in[IN_W-1:2*MID_W], ia_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            op_v & (cmd_count != '0): state_nxt = VDATA;
            op_t & (cmd_count != '0): state_nxt = TDATA;
            op_i:                     state_nxt = IDATA;
            op_u:                     state_nxt = URD;
            default:                  state_nxt = IDLE;
          endcase
        end
      end
      VDATA, TDATA: if (beat_ok & last) state_nxt = IDLE;
      IDATA, UWR:   if (beat_ok) state_nxt = IDLE;
      URD:          state_nxt = UWR;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    unique case (state)
      IDLE:                     cmd_ready  = init_q;
      VDATA, TDATA, IDATA, UWR: data_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      lat_id    <= '0;
      lat_cnt   <= '0;
      lat_base  <= '0;
      beat      <= '0;
      discard   <= 1'b0;
      vert_used <= '0;
      tri_used  <= '0;
      err       <= '0;
      vmesh_v   <= '0;
      tmesh_v   <= '0;
      inst_v    <= '0;
    end else begin
      init_q <= 1'b1;
      if (acc) begin
        lat_id   <= cmd_id;
        lat_cnt  <= cmd_count;
        lat_base <= op_t ? CNT_W'(tri_used) : CNT_W'(vert_used);
        beat     <= '0;
        discard  <= ovf_acc;
      end else if (beat_ok) begin
        beat <= beat + CNT_W'(1);
      end
      if (vd_we) vmesh_v[d_id] <= 1'b1;
      if (td_we) tmesh_v[d_id] <= 1'b1;
      if (v_cmt) vert_used <= vert_used + VC_W'(lat_cnt);
      if (t_cmt) tri_used <= tri_used + TC_W'(lat_cnt);
      if (i_wr) inst_v[iid_lat] <= 1'b1;
      if (ovf_acc) err[0] <= 1'b1;
      if (illegal | u_bad) err[1] <= 1'b1;
      if (wipe) begin
        vmesh_v   <= '0;
        tmesh_v   <= '0;
        inst_v    <= '0;
        vert_used <= '0;
        tri_used  <= '0;
        err       <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vd_we) begin
      vd_base[d_id] <= VA_W'(d_base);
      vd_cnt[d_id]  <= VC_W'(d_cnt);
    end
    if (td_we) begin
      td_base[d_id] <= TA_W'(d_base);
      td_cnt[d_id]  <= TC_W'(d_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (v_wr) vram[VA_W'(wa)] <= data_in[VTX_W-1:0];
    vert_rd_data <= vram[vert_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (t_wr) tram[TA_W'(wa)] <= data_in[TRI_W-1:0];
    tri_rd_data <= tram[tri_rd_addr];
  end

  // Port A: create/update writes and the update's mesh-id read.
  // Port B: lookup reads only.
  always_ff @(posedge clk) begin
    if (i_wr) iram[iid_lat] <= i_wdata;
    if (state == URD) ia_q <= iram[iid_lat][2*MID_W-1:0];
    ib_q <= iram[rd_inst_id];
  end

  assign s1_vm = ib_q[2*MID_W-1:MID_W];
  assign s1_tm = ib_q[MID_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s1_iv         <= 1'b0;
      rd_valid      <= 1'b0;
      rd_inst_ok    <= 1'b0;
      rd_xform      <= '0;
      rd_vert_base  <= '0;
      rd_vert_count <= '0;
      rd_tri_base   <= '0;
      rd_tri_count  <= '0;
    end else begin
      s1_v          <= rd_req;
      s1_iv         <= inst_v[rd_inst_id];
      rd_valid      <= s1_v;
      rd_inst_ok    <= s1_v & s1_iv & vmesh_v[s1_vm] & tmesh_v[s1_tm];
      rd_xform      <= ib_q[IN_W-1:2*MID_W];
      rd_vert_base  <= vd_base[s1_vm];
      rd_vert_count <= vd_cnt[s1_vm];
      rd_tri_base   <= td_base[s1_tm];
      rd_tri_count  <= td_cnt[s1_tm];
    end
  end

endmodule
